xadc_sim_model: RTL and testbench
=================================

# xadc_sim_model

Cycle-level behavioural model of the on-chip dual-port ADC primitive, exercised through its DRP register port. It holds the configuration registers, runs continuous single-channel conversions, and presents results through the DRP read path. The analog front end is replaced by a digital sample input. It stands in for the hard macro beneath the `adc` sampling wrapper in simulation.

## Interface
Parameters:
- INIT_40, 16'h0000, config reg 0: [4:0] selected channel CH.
- INIT_41, 16'h3000, config reg 1: [15:12] SEQ (stored only).
- INIT_42, 16'h0400, config reg 2: [15:8] ADCCLK divider DIV.
- CONV_ADCCLKS, 26, ADCCLK cycles per conversion.
- DRP_LAT, 2, cycles from accepted den to drdy.

Ports:
- clk  in  1  DRP clock (DCLK); everything is synchronous to it.
- rst_n  in  1  async active-low reset.
- den  in  1  DRP enable.
- dwe  in  1  DRP write enable; qualified by den.
- daddr  in  7  DRP address.
- di  in  16  DRP write data.
- sim_code  in  12  stands in for the analog input; the converted value of any channel.
- do  out  16  DRP read data; valid while drdy=1.
- drdy  out  1  one-cycle DRP completion pulse.
- eoc  out  1  one-cycle end-of-conversion pulse.
- eos  out  1  end of sequence; equals eoc in single-channel mode.
- busy  out  1  high while a conversion is in progress.
- channel  out  5  channel of the last completed conversion.
- alm  out  8  alarms; tied 0.
- ot  out  1  over-temperature; tied 0.

## Operation
- Register file of 128x16:
  - 0x00–0x3F status, read-only; cleared to 0 at reset.
  - 0x40–0x42 config; loaded from INIT_4x at reset; R/W.
  - Other addresses read 0; writes to them are ignored.
- DRP state machine IDLE→WAIT→IDLE:
  - In IDLE, den=1 latches daddr/dwe/di and enters WAIT.
  - den while in WAIT is ignored, so a multi-cycle den produces exactly one transaction.
  - A write updates the target at acceptance.
  - A read captures its data on the drdy cycle.
  - do holds its value after drdy drops.
- Conversion engine (continuous, single channel; every SEQ value behaves as single-channel):
  - DIV_eff = DIV, or 2 when DIV<2.
  - T = CONV_ADCCLKS×DIV_eff clk cycles.
  - At conversion start, sim_code is sampled and CH is latched.
  - At conversion end, status reg[CH] ← {sample,4'h0}, channel ← CH, and eoc and eos pulse.
  - The next conversion starts on the following cycle.
- Writing 0x40 or 0x41 aborts the current conversion. No eoc is issued for it, and a new conversion starts the next cycle with the new CH.
- If a conversion end and a DRP read of the same reg fall on the same cycle, the read returns the new value.

## Timing
- Reset values: do=0, drdy=0, eoc=0, eos=0, busy=0, channel=0, alm=0, ot=0. The DRP FSM is in IDLE.
- The first conversion starts on the first clk edge after rst_n deasserts, with busy=1 from that edge.
- drdy is asserted exactly DRP_LAT cycles after the den-acceptance edge, for 1 cycle.
- The first eoc follows T cycles after conversion start, so eoc pulses recur every T+1 cycles.
- busy drops on the eoc cycle and rises again on the next cycle.
- rst_n asserted mid-operation clears everything immediately: no drdy or eoc is produced for in-flight operations.

## Structure
- Shared package `xadc_pkg`:
  - register address constants: CFG0=0x40, CFG1=0x41, CFG2=0x42, AUX0=0x10;
  - DRP FSM state enum;
  - DIV_MIN=2.
- Sub-module `xadc_conv_timer`:
  - divider/conversion counter;
  - outputs the start, done and busy strobes;
  - inputs DIV and abort.
- The top level holds the register file and the DRP FSM.

## Test plan
- Reset with INIT_40=16'h0016, INIT_42=16'h0200, sim_code=12'hABC:
  - first eoc 52 cycles after release;
  - channel=5'h16;
  - read 0x16 → do=16'hABC0 on a drdy 2 cycles after den.
- Read 0x41 after reset → 16'h3000. Write 0x42 with 16'h0100 then read back → 16'h0100, and the eoc period becomes 53 cycles (DIV clamped to 2).
- Hold den high for 3 cycles → exactly one drdy pulse.
- Write 0x40=16'h0013 mid-conversion → no eoc for the aborted conversion. The next eoc arrives 52 cycles after the write, and reg 0x13 is updated while 0x16 is unchanged.
- Change sim_code from 12'h123 to 12'hFFF mid-conversion → that conversion stores 16'h1230 and the next stores 16'hFFF0.
- Assert rst_n low during a pending read and mid-conversion → outputs go 0 at once, with no drdy or eoc afterwards. Reg 0x16 reads 0 until the next eoc.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared constants, DRP FSM state and request payload for the ADC behavioural model.
package xadc_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 7;
  localparam int unsigned SW    = 12;
  localparam int unsigned CHW   = 5;
  localparam int unsigned CNT_W = 24;
  localparam int unsigned LAT_W = 8;

  localparam logic [AW-1:0] CFG0 = 7'h40;
  localparam logic [AW-1:0] CFG1 = 7'h41;
  localparam logic [AW-1:0] CFG2 = 7'h42;
  localparam logic [AW-1:0] AUX0 = 7'h10;

  localparam logic [7:0] DIV_MIN = 8'd2;

  // Status words exist for every selectable channel: 16 primaries then 16 aux from AUX0.
  localparam int unsigned NUM_STATUS = 32'(AUX0) + 32'd16;
  localparam int unsigned ST_AW      = $clog2(NUM_STATUS);

  typedef enum logic {
    DRP_IDLE,
    DRP_WAIT
  } drp_state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
  } drp_req_t;

endpackage

// File: rtl/xadc_conv_timer.sv
// Conversion timer: restarts every conversion, counting CONV_ADCCLKS x effective divider clk cycles.
module xadc_conv_timer
  import xadc_pkg::*;
#(
  parameter int unsigned CONV_ADCCLKS = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] div_i,
  input  logic       abort_i,
  output logic       start_c_o,
  output logic       done_c_o,
  output logic       busy_o
);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [7:0]       div_eff;

  // A conversion starts whenever idle or aborted; length is latched at start.
  always_comb begin
    div_eff   = (div_i < DIV_MIN) ? DIV_MIN : div_i;
    start_c_o = !busy_q || abort_i;
    done_c_o  = busy_q && !abort_i && (cnt_q == len_q);
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    if (start_c_o) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(1);
      len_d  = CNT_W'(CONV_ADCCLKS) * CNT_W'(div_eff);
    end else if (done_c_o) begin
      busy_d = 1'b0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      len_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/xadc_sim_model.sv
// Behavioural ADC model: DRP register file, DRP handshake FSM and continuous single-channel conversion.
module xadc_sim_model
  import xadc_pkg::*;
#(
  parameter logic [15:0] INIT_40      = 16'h0000,
  parameter logic [15:0] INIT_41      = 16'h3000,
  parameter logic [15:0] INIT_42      = 16'h0400,
  parameter int unsigned CONV_ADCCLKS = 26,
  parameter int unsigned DRP_LAT      = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          den_i,
  input  logic          dwe_i,
  input  logic [AW-1:0] daddr_i,
  input  logic [DW-1:0] di_i,
  input  logic [SW-1:0] sim_code_i,
  output logic [DW-1:0] do_o,
  output logic          drdy_o,
  output logic          eoc_o,
  output logic          eos_o,
  output logic          busy_o,
  output logic [CHW-1:0] channel_o,
  output logic [7:0]    alm_o,
  output logic          ot_o
);

  drp_state_e       state_q, state_d;
  drp_req_t         req_q, req_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [DW-1:0]    cfg0_q, cfg0_d, cfg1_q, cfg1_d, cfg2_q, cfg2_d;
  logic [DW-1:0]    status_q [NUM_STATUS];
  logic [DW-1:0]    status_d [NUM_STATUS];
  logic [DW-1:0]    do_q, do_d;
  logic             drdy_q, drdy_d, eoc_q, eoc_d;
  logic [CHW-1:0]   ch_q, ch_d, channel_q, channel_d;
  logic [SW-1:0]    sample_q, sample_d;
  logic             accept_c, wr_cfg0_c, abort_c, start_c, done_c, conv_busy;
  logic [DW-1:0]    rdata_c;

  assign accept_c  = (state_q == DRP_IDLE) && den_i;
  assign wr_cfg0_c = accept_c && dwe_i && (daddr_i == CFG0);
  assign abort_c   = wr_cfg0_c || (accept_c && dwe_i && (daddr_i == CFG1));

  xadc_conv_timer #(.CONV_ADCCLKS(CONV_ADCCLKS)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_i     (cfg2_q[15:8]),
    .abort_i   (abort_c),
    .start_c_o (start_c),
    .done_c_o  (done_c),
    .busy_o    (conv_busy)
  );

  // Conversion capture; a restart caused by a CFG0 write must pick up the channel being written.
  always_comb begin
    status_d  = status_q;
    sample_d  = sample_q;
    ch_d      = ch_q;
    channel_d = channel_q;
    eoc_d     = 1'b0;
    if (done_c) begin
      status_d[ST_AW'(ch_q)] = {sample_q, 4'h0};
      channel_d              = ch_q;
      eoc_d                  = 1'b1;
    end
    if (start_c) begin
      sample_d = sim_code_i;
      ch_d     = wr_cfg0_c ? di_i[CHW-1:0] : cfg0_q[CHW-1:0];
    end
  end

  // Status reads come from the next-state array so a same-cycle conversion result is returned.
  always_comb begin
    rdata_c = '0;
    if (32'(req_q.addr) < NUM_STATUS) begin
      rdata_c = status_d[ST_AW'(req_q.addr)];
    end else begin
      case (req_q.addr)
        CFG0:    rdata_c = cfg0_q;
        CFG1:    rdata_c = cfg1_q;
        CFG2:    rdata_c = cfg2_q;
        default: rdata_c = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    lat_d   = lat_q;
    drdy_d  = 1'b0;
    do_d    = do_q;
    cfg0_d  = cfg0_q;
    cfg1_d  = cfg1_q;
    cfg2_d  = cfg2_q;
    case (state_q)
      DRP_IDLE: begin
        if (accept_c) begin
          req_d   = '{addr: daddr_i, we: dwe_i};
          lat_d   = LAT_W'(DRP_LAT - 1);
          state_d = DRP_WAIT;
          if (dwe_i) begin
            case (daddr_i)
              CFG0:    cfg0_d = di_i;
              CFG1:    cfg1_d = di_i;
              CFG2:    cfg2_d = di_i;
              default: ;
            endcase
          end
        end
      end
      DRP_WAIT: begin
        if (lat_q == '0) begin
          drdy_d  = 1'b1;
          state_d = DRP_IDLE;
          if (!req_q.we) do_d = rdata_c;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: state_d = DRP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DRP_IDLE;
      req_q     <= '0;
      lat_q     <= '0;
      cfg0_q    <= INIT_40;
      cfg1_q    <= INIT_41;
      cfg2_q    <= INIT_42;
      do_q      <= '0;
      drdy_q    <= 1'b0;
      eoc_q     <= 1'b0;
      ch_q      <= '0;
      channel_q <= '0;
      sample_q  <= '0;
      for (int unsigned i = 0; i < NUM_STATUS; i++) status_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      lat_q     <= lat_d;
      cfg0_q    <= cfg0_d;
      cfg1_q    <= cfg1_d;
      cfg2_q    <= cfg2_d;
      do_q      <= do_d;
      drdy_q    <= drdy_d;
      eoc_q     <= eoc_d;
      ch_q      <= ch_d;
      channel_q <= channel_d;
      sample_q  <= sample_d;
      status_q  <= status_d;
    end
  end

  assign do_o      = do_q;
  assign drdy_o    = drdy_q;
  assign eoc_o     = eoc_q;
  assign eos_o     = eoc_q;
  assign busy_o    = conv_busy;
  assign channel_o = channel_q;
  assign alm_o     = '0;
  assign ot_o      = 1'b0;

endmodule

// File: tb/tb_xadc_sim_model.sv
// Directed bench for xadc_sim_model: DRP vector table plus conversion timing, abort and reset sequences.
module tb_xadc_sim_model;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        den, dwe;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [11:0] sim_code;
  logic [15:0] do_w;
  logic        drdy, eoc, eos, busy, ot;
  logic [4:0]  channel;
  logic [7:0]  alm;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int eoc_cnt = 0, eos_cnt = 0, drdy_cnt = 0;
  int last_eoc = 0, busy_rise = 0;
  logic prev_busy = 1'b0;

  typedef struct {
    logic [6:0]  addr;
    logic        we;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  xadc_sim_model #(
    .INIT_40 (16'h0016),
    .INIT_42 (16'h0200)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .den_i      (den),
    .dwe_i      (dwe),
    .daddr_i    (daddr),
    .di_i       (di),
    .sim_code_i (sim_code),
    .do_o       (do_w),
    .drdy_o     (drdy),
    .eoc_o      (eoc),
    .eos_o      (eos),
    .busy_o     (busy),
    .channel_o  (channel),
    .alm_o      (alm),
    .ot_o       (ot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eoc) begin
      eoc_cnt  <= eoc_cnt + 1;
      last_eoc <= cyc;
    end
    if (eos) eos_cnt <= eos_cnt + 1;
    if (drdy) drdy_cnt <= drdy_cnt + 1;
    if (busy && !prev_busy) busy_rise <= cyc;
    prev_busy <= busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one DRP access at the current negedge; lat = cycles from acceptance edge to drdy.
  task automatic drp_xfer(input logic [6:0] a, input logic we, input logic [15:0] wd,
                          output logic [15:0] rd, output int lat, output int acc);
    den = 1'b1; dwe = we; daddr = a; di = wd;
    @(posedge clk);
    #1;
    acc = cyc;
    den = 1'b0; dwe = 1'b0;
    lat = -1;
    rd  = 16'hDEAD;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (drdy) begin
        lat = k;
        rd  = do_w;
        break;
      end
    end
    #1;
  endtask

  task automatic wait_next_eoc(output int c);
    int  n0;
    bit  got;
    n0  = eoc_cnt;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      #1;
      if (eoc_cnt != n0) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL eoc_timeout: no eoc within 200 cycles");
    end
    c = last_eoc;
  endtask

  initial begin
    logic [15:0] rd;
    int lat, acc, e, e_a, e_b, d0, e0, w;
    vec_t vecs [11];

    rst_n = 1'b0; den = 1'b0; dwe = 1'b0; daddr = '0; di = '0; sim_code = 12'hABC;
    repeat (3) @(negedge clk);
    chk("rst_do", 32'(do_w), 0);
    chk("rst_drdy", 32'(drdy), 0);
    chk("rst_eoc", 32'(eoc), 0);
    chk("rst_eos", 32'(eos), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_channel", 32'(channel), 0);
    chk("rst_alm", 32'(alm), 0);
    chk("rst_ot", 32'(ot), 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("busy_after_release", 32'(busy), 1);

    wait_next_eoc(e);
    chk("first_eoc_latency", 32'(e - busy_rise), 52);
    chk("first_eoc_channel", 32'(channel), 32'h16);
    chk("eos_with_eoc", 32'(eos), 1);
    chk("busy_low_on_eoc", 32'(busy), 0);
    @(negedge clk);
    #1;
    chk("busy_restart", 32'(busy), 1);
    chk("eoc_one_cycle", 32'(eoc), 0);
    drp_xfer(7'h16, 1'b0, 16'h0, rd, lat, acc);
    chk("rd16_lat", 32'(lat), 2);
    chk("rd16_data", 32'(rd), 32'hABC0);

    vecs[0]  = '{7'h41, 1'b0, 16'h0000, 16'h3000};
    vecs[1]  = '{7'h40, 1'b0, 16'h0000, 16'h0016};
    vecs[2]  = '{7'h42, 1'b0, 16'h0000, 16'h0200};
    vecs[3]  = '{7'h7F, 1'b1, 16'hBEEF, 16'h0000};
    vecs[4]  = '{7'h7F, 1'b0, 16'h0000, 16'h0000};
    vecs[5]  = '{7'h42, 1'b1, 16'h0100, 16'h0000};
    vecs[6]  = '{7'h42, 1'b0, 16'h0000, 16'h0100};
    vecs[7]  = '{7'h3F, 1'b0, 16'h0000, 16'h0000};
    vecs[8]  = '{7'h05, 1'b1, 16'h1234, 16'h0000};
    vecs[9]  = '{7'h05, 1'b0, 16'h0000, 16'h0000};
    vecs[10] = '{7'h16, 1'b0, 16'h0000, 16'hABC0};
    for (int i = 0; i < 11; i++) begin
      drp_xfer(vecs[i].addr, vecs[i].we, vecs[i].wd, rd, lat, acc);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 2);
      if (!vecs[i].we) chk($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].exp));
    end

    // DIV=1 clamps to 2, then DIV=3 stretches the period
    wait_next_eoc(e_a);
    wait_next_eoc(e_b);
    chk("period_div_clamped", 32'(e_b - e_a), 53);
    drp_xfer(7'h42, 1'b1, 16'h0300, rd, lat, acc);
    wait_next_eoc(e_a);
    wait_next_eoc(e_b);
    chk("period_div3", 32'(e_b - e_a), 79);
    drp_xfer(7'h42, 1'b1, 16'h0200, rd, lat, acc);

    // Multi-cycle den yields one transaction
    d0 = drdy_cnt;
    den = 1'b1; dwe = 1'b0; daddr = 7'h41;
    repeat (3) @(negedge clk);
    den = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("long_den_one_drdy", 32'(drdy_cnt - d0), 1);
    chk("long_den_data", 32'(do_w), 32'h3000);

    // Abort via CFG0 write
    wait_next_eoc(e);
    repeat (20) @(negedge clk);
    sim_code = 12'h555;
    drp_xfer(7'h40, 1'b1, 16'h0013, rd, lat, acc);
    wait_next_eoc(e);
    chk("abort_cfg0_eoc_delay", 32'(e - acc), 52);
    chk("abort_cfg0_channel", 32'(channel), 32'h13);
    drp_xfer(7'h13, 1'b0, 16'h0, rd, lat, acc);
    chk("abort_rd13", 32'(rd), 32'h5550);
    drp_xfer(7'h16, 1'b0, 16'h0, rd, lat, acc);
    chk("abort_rd16_kept", 32'(rd), 32'hABC0);

    // Abort via CFG1 write
    wait_next_eoc(e);
    repeat (15) @(negedge clk);
    drp_xfer(7'h41, 1'b1, 16'h3000, rd, lat, acc);
    wait_next_eoc(e);
    chk("abort_cfg1_eoc_delay", 32'(e - acc), 52);

    // Sample is taken at conversion start
    sim_code = 12'h123;
    wait_next_eoc(e);
    repeat (10) @(negedge clk);
    sim_code = 12'hFFF;
    wait_next_eoc(e);
    drp_xfer(7'h13, 1'b0, 16'h0, rd, lat, acc);
    chk("sample_at_start_1", 32'(rd), 32'h1230);
    sim_code = 12'h2A5;
    wait_next_eoc(e_a);
    drp_xfer(7'h13, 1'b0, 16'h0, rd, lat, acc);
    chk("sample_at_start_2", 32'(rd), 32'hFFF0);

    // Read whose drdy coincides with the eoc of the same register
    w = 0;
    while (cyc != e_a + 50 && w < 100) begin
      @(negedge clk);
      w++;
    end
    drp_xfer(7'h13, 1'b0, 16'h0, rd, lat, acc);
    chk("bypass_eoc_same_cycle", 32'(last_eoc), 32'(e_a + 53));
    chk("bypass_rd_new", 32'(rd), 32'h2A50);

    // Reset during a pending read and a running conversion
    repeat (10) @(negedge clk);
    d0 = drdy_cnt;
    e0 = eoc_cnt;
    daddr = 7'h16; dwe = 1'b0; den = 1'b1;
    @(posedge clk);
    #1;
    den = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_do", 32'(do_w), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_channel", 32'(channel), 0);
    chk("midrst_drdy", 32'(drdy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drp_xfer(7'h16, 1'b0, 16'h0, rd, lat, acc);
    chk("postrst_rd16", 32'(rd), 0);
    drp_xfer(7'h40, 1'b0, 16'h0, rd, lat, acc);
    chk("postrst_cfg0", 32'(rd), 32'h0016);
    drp_xfer(7'h13, 1'b0, 16'h0, rd, lat, acc);
    chk("postrst_rd13", 32'(rd), 0);
    chk("postrst_no_stray_drdy", 32'(drdy_cnt - d0), 3);
    chk("postrst_no_stray_eoc", 32'(eoc_cnt - e0), 0);
    wait_next_eoc(e);
    chk("postrst_eoc_latency", 32'(e - busy_rise), 52);
    drp_xfer(7'h16, 1'b0, 16'h0, rd, lat, acc);
    chk("postrst_rd16_converted", 32'(rd), 32'h2A50);
    chk("eos_tracks_eoc", 32'(eos_cnt), 32'(eoc_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
